// File: rtl/drift_corrector_pkg.sv
// Shared clock-domain bundle and clock-recovery types for the drift correction path.
// The STATS_EN feature macro (DRIFT_CORRECTOR_STATS_EN) is consumed by drift_corrector.sv.
package common_p;
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int DRIFT_COUNTER_WIDTH               = 8;
    localparam int DRIFT_CORRECTOR_HALF_PERIOD_WIDTH = 16;

    typedef enum logic {
        PIN_CAME_EARLY = 1'b0,
        PIN_CAME_LATE  = 1'b1
    } drift_direction_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } corrector_state_e;
endpackage

// File: rtl/half_period_counter.sv
// Reload/decrement down-counter; o_zero flags the half-period boundary cycle.
module half_period_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_ce) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/drift_corrector.sv
// Recovered-clock edge generator that answers drift requests by stretching or shrinking one half-period.
// Define DRIFT_CORRECTOR_STATS_EN to add early/late counters and a |net drift| high-water mark.
module drift_corrector
    import common_p::*;
    import clks_alot_p::*;
#(
    parameter int HALF_PERIOD_WIDTH = DRIFT_CORRECTOR_HALF_PERIOD_WIDTH,
    parameter int NET_DRIFT_WIDTH   = DRIFT_COUNTER_WIDTH
) (
    input  clk_dom_s                            sys_dom_i,
    input  logic                                corrector_en_i,
    input  logic                                clear_state_i,
    input  logic [HALF_PERIOD_WIDTH-1:0]        half_period_i,
    input  logic [HALF_PERIOD_WIDTH-1:0]        adjust_step_i,
    input  logic                                drift_req_i,
    input  drift_direction_e                    drift_direction_i,
    output logic                                drift_res_o,
    output logic                                rise_o,
    output logic                                fall_o,
    output logic                                clk_level_o,
    output logic signed [NET_DRIFT_WIDTH-1:0]   net_drift_o,
    output logic                                net_drift_saturated_o
`ifdef DRIFT_CORRECTOR_STATS_EN
    ,
    output logic [15:0]                         early_count_o,
    output logic [15:0]                         late_count_o,
    output logic [NET_DRIFT_WIDTH-1:0]          max_abs_net_drift_o
`endif
);
    localparam logic signed [NET_DRIFT_WIDTH-1:0] NET_MAX = {1'b0, {(NET_DRIFT_WIDTH-1){1'b1}}};
    localparam logic signed [NET_DRIFT_WIDTH-1:0] NET_MIN = {1'b1, {(NET_DRIFT_WIDTH-1){1'b0}}};
    localparam logic signed [NET_DRIFT_WIDTH-1:0] NET_ONE = NET_DRIFT_WIDTH'(1);

    function automatic logic [HALF_PERIOD_WIDTH-1:0] sat_shorten(
        input logic [HALF_PERIOD_WIDTH-1:0] nom,
        input logic [HALF_PERIOD_WIDTH-1:0] step
    );
        return (nom > step) ? (nom - step) : '0;
    endfunction

    // One extra bit catches the carry so a long step clamps instead of wrapping short.
    function automatic logic [HALF_PERIOD_WIDTH-1:0] sat_lengthen(
        input logic [HALF_PERIOD_WIDTH-1:0] nom,
        input logic [HALF_PERIOD_WIDTH-1:0] step
    );
        logic [HALF_PERIOD_WIDTH:0] sum;
        sum = {1'b0, nom} + {1'b0, step};
        return sum[HALF_PERIOD_WIDTH] ? '1 : sum[HALF_PERIOD_WIDTH-1:0];
    endfunction

    function automatic logic signed [NET_DRIFT_WIDTH-1:0] sat_net_step(
        input logic signed [NET_DRIFT_WIDTH-1:0] net,
        input logic                              late
    );
        if (late) return (net == NET_MAX) ? net : (net + NET_ONE);
        else      return (net == NET_MIN) ? net : (net - NET_ONE);
    endfunction

    function automatic logic [NET_DRIFT_WIDTH-1:0] abs_net(
        input logic signed [NET_DRIFT_WIDTH-1:0] net
    );
        return net[NET_DRIFT_WIDTH-1] ? unsigned'(-net) : unsigned'(net);
    endfunction

    corrector_state_e                   r_state;
    logic                               r_level;
    logic                               r_rise;
    logic                               r_fall;
    logic                               r_res;
    logic signed [NET_DRIFT_WIDTH-1:0]  r_net;

    logic                               w_ce;
    logic                               w_zero;
    logic                               w_cnt_rst;
    logic                               w_boundary;
    logic                               w_adjust;
    logic                               w_late;
    logic                               w_cnt_load;
    logic                               w_cnt_dec;
    logic [HALF_PERIOD_WIDTH-1:0]       w_hp_eff;
    logic [HALF_PERIOD_WIDTH-1:0]       w_nom;
    logic [HALF_PERIOD_WIDTH-1:0]       w_reload;
    logic signed [NET_DRIFT_WIDTH-1:0]  w_net_next;

    always_comb begin
        w_ce       = sys_dom_i.clk_en;
        w_cnt_rst  = sys_dom_i.sync_rst || (w_ce && clear_state_i);
        w_hp_eff   = (half_period_i == '0) ? HALF_PERIOD_WIDTH'(1) : half_period_i;
        w_nom      = w_hp_eff - HALF_PERIOD_WIDTH'(1);
        w_late     = (drift_direction_i == PIN_CAME_LATE);
        w_boundary = (r_state == RUN) && w_zero && corrector_en_i;
        // A request on the boundary cycle itself is honoured here, so latency is at most one half-period.
        w_adjust   = w_boundary && drift_req_i && !clear_state_i;
        w_reload   = w_nom;
        if (w_adjust) begin
            w_reload = w_late ? sat_lengthen(w_nom, adjust_step_i)
                              : sat_shorten(w_nom, adjust_step_i);
        end
        w_cnt_load = (r_state == LOAD) || w_boundary;
        w_cnt_dec  = (r_state == RUN) && corrector_en_i && !w_zero;
        w_net_next = sat_net_step(r_net, w_late);
    end

    half_period_counter #(
        .WIDTH (HALF_PERIOD_WIDTH)
    ) u_counter (
        .i_clk      (sys_dom_i.clk),
        .i_rst      (w_cnt_rst),
        .i_ce       (w_ce),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (w_reload),
        .o_zero     (w_zero)
    );

`ifdef DRIFT_CORRECTOR_STATS_EN
    logic [15:0]                r_early_cnt;
    logic [15:0]                r_late_cnt;
    logic [NET_DRIFT_WIDTH-1:0] r_max_abs;
    logic [NET_DRIFT_WIDTH-1:0] w_abs_next;

    assign w_abs_next = abs_net(w_net_next);
`endif

    always_ff @(posedge sys_dom_i.clk) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_res  <= 1'b0;
        if (sys_dom_i.sync_rst || (w_ce && clear_state_i)) begin
            r_state <= IDLE;
            r_level <= 1'b0;
            r_net   <= '0;
`ifdef DRIFT_CORRECTOR_STATS_EN
            r_early_cnt <= '0;
            r_late_cnt  <= '0;
            r_max_abs   <= '0;
`endif
        end else if (w_ce) begin
            case (r_state)
                IDLE: if (corrector_en_i) r_state <= LOAD;
                LOAD: r_state <= RUN;
                RUN: begin
                    // Disabling only takes effect at a boundary, leaving the level where it was.
                    if (w_zero && !corrector_en_i) begin
                        r_state <= IDLE;
                    end else if (w_boundary) begin
                        r_level <= ~r_level;
                        r_rise  <= ~r_level;
                        r_fall  <= r_level;
                        if (w_adjust) begin
                            r_res <= 1'b1;
                            r_net <= w_net_next;
`ifdef DRIFT_CORRECTOR_STATS_EN
                            if (w_late) begin
                                if (r_late_cnt != 16'hFFFF) r_late_cnt <= r_late_cnt + 16'd1;
                            end else begin
                                if (r_early_cnt != 16'hFFFF) r_early_cnt <= r_early_cnt + 16'd1;
                            end
                            if (w_abs_next > r_max_abs) r_max_abs <= w_abs_next;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign drift_res_o           = r_res;
    assign rise_o                = r_rise;
    assign fall_o                = r_fall;
    assign clk_level_o           = r_level;
    assign net_drift_o           = r_net;
    assign net_drift_saturated_o = (r_net == NET_MAX) || (r_net == NET_MIN);

`ifdef DRIFT_CORRECTOR_STATS_EN
    assign early_count_o       = r_early_cnt;
    assign late_count_o        = r_late_cnt;
    assign max_abs_net_drift_o = r_max_abs;
`endif
endmodule
